trace_event_packer: RTL and testbench

- Synthesizable producer side of the CPU retirement trace.
- Samples per-cycle commit events from the pipeline: register write, memory load, memory store and halt.
- Packs each event into 16-bit trace words, buffers them in a snapshot FIFO, and drains them over a valid/ready stream.
- On halt, appends a summary record holding the cycle and instruction counts, then reports done.
- Sits beside the cpu top level and feeds an off-chip logger or a bench-side checker.

---
 rtl/trace_event_packer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_trace_event_packer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/trace_event_packer.sv
// Retirement-trace producer: captures commit events, buffers snapshots in a FIFO and
// serializes them as 16-bit words on a valid/ready stream. Optional macro: TRACE_SKIP_R0_EN.
module trace_event_packer #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        reg_wr,
    input  logic [3:0]  reg_addr,
    input  logic [15:0] reg_data,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        overflow,
    output logic        done,
    output logic [31:0] cycle_count,
    output logic [31:0] inst_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_REG_HDR  = 4'd1,
        S_REG_DATA = 4'd2,
        S_MEM_HDR  = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_DATA = 4'd5,
        S_SUM_HDR  = 4'd6,
        S_CYC_HI   = 4'd7,
        S_CYC_LO   = 4'd8,
        S_INST_HI  = 4'd9,
        S_INST_LO  = 4'd10,
        S_DONE     = 4'd11
    } state_t;

    typedef struct packed {
        logic        f_reg;
        logic        f_load;
        logic        f_store;
        logic        f_halt;
        logic [3:0]  reg_addr;
        logic [15:0] reg_data;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic [15:0] mem_rdata;
        logic [7:0]  seq;
    } snap_t;

    function automatic state_t first_state(input snap_t s);
        if (s.f_reg) begin
            return S_REG_HDR;
        end else if (s.f_load | s.f_store) begin
            return S_MEM_HDR;
        end else begin
            return S_SUM_HDR;
        end
    endfunction

    // Successor word within a snapshot; only consulted when the current word is not last.
    function automatic state_t next_part(input state_t st, input snap_t s);
        case (st)
            S_REG_HDR:  return S_REG_DATA;
            S_REG_DATA: return (s.f_load | s.f_store) ? S_MEM_HDR : S_SUM_HDR;
            S_MEM_HDR:  return S_MEM_ADDR;
            S_MEM_ADDR: return S_MEM_DATA;
            S_MEM_DATA: return S_SUM_HDR;
            S_SUM_HDR:  return S_CYC_HI;
            S_CYC_HI:   return S_CYC_LO;
            S_CYC_LO:   return S_INST_HI;
            S_INST_HI:  return S_INST_LO;
            default:    return S_IDLE;
        endcase
    endfunction

    // Returns {last, data} for the word presented in state st.
    function automatic logic [16:0] word_of(input state_t st, input snap_t s,
                                            input logic [31:0] cyc, input logic [31:0] inst);
        logic [3:0] mem_type;
        mem_type = s.f_store ? 4'h3 : 4'h2;
        case (st)
            S_REG_HDR:  return {1'b0, 4'h1, s.reg_addr, s.seq};
            S_REG_DATA: return {~(s.f_load | s.f_store | s.f_halt), s.reg_data};
            S_MEM_HDR:  return {1'b0, mem_type, 4'h0, s.seq};
            S_MEM_ADDR: return {1'b0, s.mem_addr};
            S_MEM_DATA: return {~s.f_halt, s.f_store ? s.mem_wdata : s.mem_rdata};
            S_SUM_HDR:  return {1'b0, 4'hF, 4'h0, s.seq};
            S_CYC_HI:   return {1'b0, cyc[31:16]};
            S_CYC_LO:   return {1'b0, cyc[15:0]};
            S_INST_HI:  return {1'b0, inst[31:16]};
            S_INST_LO:  return {1'b1, inst[15:0]};
            default:    return 17'd0;
        endcase
    endfunction

    logic          cnt_en, ev_reg, ev_load, ev_store, ev_any;
    logic          push, pop, drop, full, empty, xfer;
    snap_t         cap_d, cap_q, push_snap, head, cur_d, cur_q;
    logic          cap_valid_d, cap_valid_q;
    logic [AW:0]   count_d, count_q;
    logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [7:0]    seq_d, seq_q;
    logic          halt_d, halt_q, overflow_d, overflow_q;
    logic [31:0]   cycle_count_d, cycle_count_q, inst_count_d, inst_count_q;
    state_t        state_d, state_q;
    logic          out_valid_d, out_valid_q, out_last_d, out_last_q, done_d, done_q;
    logic [15:0]   out_data_d, out_data_q;
    snap_t         fifo_q [DEPTH];

    assign head = fifo_q[rd_ptr_q];

    // Capture stage, FIFO bookkeeping, counters and sticky status.
    always_comb begin
        cnt_en   = en & ~halt_q;
`ifdef TRACE_SKIP_R0_EN
        ev_reg   = reg_wr & (reg_addr != 4'd0);
`else
        ev_reg   = reg_wr;
`endif
        ev_store = mem_wr;
        ev_load  = mem_rd & ~mem_wr;
        ev_any   = ev_reg | ev_load | ev_store | halt;

        full  = (count_q == CNT_FULL);
        empty = (count_q == (AW+1)'(0));
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push  = cap_valid_q & (~full | pop);
        drop  = cap_valid_q & ~push & ~cap_q.f_halt;

        push_snap     = cap_q;
        push_snap.seq = seq_q;

        cap_d       = cap_q;
        cap_valid_d = cap_valid_q & ~push & cap_q.f_halt;
        if (cnt_en & ev_any) begin
            cap_d.f_reg     = ev_reg;
            cap_d.f_load    = ev_load;
            cap_d.f_store   = ev_store;
            cap_d.f_halt    = halt;
            cap_d.reg_addr  = reg_addr;
            cap_d.reg_data  = reg_data;
            cap_d.mem_addr  = mem_addr;
            cap_d.mem_wdata = mem_wdata;
            cap_d.mem_rdata = mem_rdata;
            cap_d.seq       = 8'd0;
            cap_valid_d     = 1'b1;
        end else begin
            cap_d = cap_q;
        end

        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        seq_d      = push ? (seq_q + 8'd1) : seq_q;
        overflow_d = overflow_q | drop;
        halt_d     = halt_q | (cnt_en & halt);

        if (cnt_en && (cycle_count_q != 32'hFFFF_FFFF)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end else begin
            cycle_count_d = cycle_count_q;
        end
        if (cnt_en && (reg_wr | mem_wr | halt) && (inst_count_q != 32'hFFFF_FFFF)) begin
            inst_count_d = inst_count_q + 32'd1;
        end else begin
            inst_count_d = inst_count_q;
        end
    end

    // Serializer next state and the registered word it will present.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pop     = 1'b0;
        xfer    = out_valid_q & out_ready;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    cur_d   = head;
                    state_d = first_state(head);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: state_d = S_DONE;
            S_REG_HDR, S_REG_DATA, S_MEM_HDR, S_MEM_ADDR, S_MEM_DATA,
            S_SUM_HDR, S_CYC_HI, S_CYC_LO, S_INST_HI, S_INST_LO: begin
                if (!xfer) begin
                    state_d = state_q;
                end else if (!out_last_q) begin
                    state_d = next_part(state_q, cur_q);
                end else if (cur_q.f_halt) begin
                    state_d = S_DONE;
                end else if (!empty) begin
                    pop     = 1'b1;
                    cur_d   = head;
                    state_d = first_state(head);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        {out_last_d, out_data_d} = word_of(state_d, cur_d, cycle_count_q, inst_count_q);
        out_valid_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
    end

    // State, control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q         <= '0;
            cap_valid_q   <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            seq_q         <= 8'd0;
            halt_q        <= 1'b0;
            overflow_q    <= 1'b0;
            cycle_count_q <= 32'd0;
            inst_count_q  <= 32'd0;
            state_q       <= S_IDLE;
            cur_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 16'd0;
            out_last_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            cap_q         <= cap_d;
            cap_valid_q   <= cap_valid_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            seq_q         <= seq_d;
            halt_q        <= halt_d;
            overflow_q    <= overflow_d;
            cycle_count_q <= cycle_count_d;
            inst_count_q  <= inst_count_d;
            state_q       <= state_d;
            cur_q         <= cur_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            done_q        <= done_d;
        end
    end

    // Snapshot storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_q[wr_ptr_q] <= push_snap;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign overflow    = overflow_q;
    assign done        = done_q;
    assign cycle_count = cycle_count_q;
    assign inst_count  = inst_count_q;

endmodule

// File: tb/tb_trace_event_packer.sv
// Directed self-checking bench for trace_event_packer (DEPTH=16).
module tb_trace_event_packer;

    logic        clk = 1'b0;
    logic        rst, en, reg_wr, mem_rd, mem_wr, halt, out_ready;
    logic [3:0]  reg_addr;
    logic [15:0] reg_data, mem_addr, mem_wdata, mem_rdata;
    logic        out_valid, out_last, overflow, done;
    logic [15:0] out_data;
    logic [31:0] cycle_count, inst_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    trace_event_packer #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .overflow(overflow), .done(done),
        .cycle_count(cycle_count), .inst_count(inst_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ev();
        reg_wr = 1'b0; reg_addr = 4'd0; reg_data = 16'd0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = 16'd0;
        mem_wdata = 16'd0; mem_rdata = 16'd0; halt = 1'b0;
    endtask

    // Waits for a word, checks it (optionally stalled one cycle first), then transfers it.
    task automatic expect_word(input string tag, input logic [15:0] data, input logic last,
                               input bit stall);
        int waited = 0;
        out_ready = ~stall;
        while (!out_valid && waited < 40) begin
            tick();
            waited++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(data));
        check({tag, "_last"}, 32'(out_last), 32'(last));
        if (stall) begin
            tick();
            check({tag, "_hold"}, {15'd0, out_valid, out_last, out_data}, {15'd0, 1'b1, last, data});
            out_ready = 1'b1;
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] sq;
        logic [3:0] ty;
        bit seen;
        rst = 1'b1; en = 1'b0; out_ready = 1'b0;
        clear_ev();

        // Reset and idle counting
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cyc", cycle_count, 32'd0);
        check("rst_inst", inst_count, 32'd0);
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_ovf", 32'(overflow), 32'd0);
        check("idle_cyc", cycle_count, 32'd5);
        check("idle_inst", inst_count, 32'd0);

        // Single register write: latency of two edges
        out_ready = 1'b1;
        reg_wr = 1'b1; reg_addr = 4'd3; reg_data = 16'h00A5;
        tick();
        clear_ev();
        check("lat_e0", 32'(out_valid), 32'd0);
        tick();
        check("lat_e1", 32'(out_valid), 32'd0);
        tick();
        check("lat_e2", 32'(out_valid), 32'd1);
        check("reg_hdr", 32'(out_data), 32'h1300);
        check("reg_hdr_last", 32'(out_last), 32'd0);
        tick();
        check("reg_data", 32'(out_data), 32'h00A5);
        check("reg_data_last", 32'(out_last), 32'd1);
        tick();
        check("reg_after", 32'(out_valid), 32'd0);

        // Register write plus load in one cycle
        reg_wr = 1'b1; reg_addr = 4'd2; reg_data = 16'h1234;
        mem_rd = 1'b1; mem_addr = 16'h0040; mem_rdata = 16'h1234;
        tick();
        clear_ev();
        expect_word("rl0", 16'h1201, 1'b0, 1'b0);
        expect_word("rl1", 16'h1234, 1'b0, 1'b0);
        expect_word("rl2", 16'h2001, 1'b0, 1'b0);
        expect_word("rl3", 16'h0040, 1'b0, 1'b0);
        expect_word("rl4", 16'h1234, 1'b1, 1'b0);
        check("rl_inst", inst_count, 32'd2);

        // 20 stores while stalled: one snapshot in the serializer plus 16 buffered
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mem_wr = 1'b1; mem_addr = 16'h0100 + 16'(i); mem_wdata = 16'hB000 + 16'(i);
            tick();
        end
        clear_ev();
        tick();
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_stall_data", 32'(out_data), 32'h3002);
        tick(); tick();
        check("ovf_stall_hold", {15'd0, out_valid, out_last, out_data}, {15'd0, 1'b1, 1'b0, 16'h3002});
        check("ovf_inst", inst_count, 32'd22);
        for (int i = 0; i < 17; i++) begin
            sq = 8'(2 + i);
            expect_word("st_hdr", {4'h3, 4'h0, sq}, 1'b0, 1'b0);
            expect_word("st_addr", 16'h0100 + 16'(i), 1'b0, 1'b0);
            expect_word("st_data", 16'hB000 + 16'(i), 1'b1, 1'b0);
        end
        tick();
        check("ovf_drained", 32'(out_valid), 32'd0);

        // Halt while the FIFO is full
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1; out_ready = 1'b0;
        check("rst2_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 17; i++) begin
            if (i < 3) mem_wr = 1'b1; else mem_rd = 1'b1;
            mem_addr = 16'h0200 + 16'(i);
            mem_wdata = 16'hC000 + 16'(i);
            mem_rdata = 16'hC000 + 16'(i);
            tick();
            clear_ev();
        end
        halt = 1'b1;
        tick();
        clear_ev();
        reg_wr = 1'b1; reg_addr = 4'd5;
        tick(); tick(); tick();
        clear_ev();
        check("halt_cyc_frozen", cycle_count, 32'd18);
        check("halt_inst_frozen", inst_count, 32'd4);
        check("halt_no_ovf", 32'(overflow), 32'd0);
        check("halt_not_done", 32'(done), 32'd0);
        check("halt_stall_data", 32'(out_data), 32'h3000);
        for (int i = 0; i < 17; i++) begin
            sq = 8'(i);
            ty = (i < 3) ? 4'h3 : 4'h2;
            expect_word("h_hdr", {ty, 4'h0, sq}, 1'b0, i[0]);
            expect_word("h_addr", 16'h0200 + 16'(i), 1'b0, ~i[0]);
            expect_word("h_data", 16'hC000 + 16'(i), 1'b1, i[0]);
        end
        expect_word("sum_hdr", 16'hF011, 1'b0, 1'b1);
        expect_word("sum_cyc_hi", 16'h0000, 1'b0, 1'b0);
        expect_word("sum_cyc_lo", 16'h0012, 1'b0, 1'b1);
        expect_word("sum_inst_hi", 16'h0000, 1'b0, 1'b0);
        expect_word("sum_inst_lo", 16'h0004, 1'b1, 1'b1);
        tick();
        check("done_set", 32'(done), 32'd1);
        check("done_valid", 32'(out_valid), 32'd0);

        // Reset while the store address word is presented
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        check("rst3_done", 32'(done), 32'd0);
        mem_wr = 1'b1; mem_addr = 16'h0300; mem_wdata = 16'h1111;
        tick();
        clear_ev();
        expect_word("mid_hdr", 16'h3000, 1'b0, 1'b0);
        out_ready = 1'b0;
        check("mid_addr", 32'(out_data), 32'h0300);
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_cyc", cycle_count, 32'd0);
        check("mid_rst_inst", inst_count, 32'd0);
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("mid_discarded", 32'(out_valid), 32'd0);

        // Register write to R0
        en = 1'b1;
        reg_wr = 1'b1; reg_addr = 4'd0; reg_data = 16'h5555;
        tick();
        clear_ev();
`ifdef TRACE_SKIP_R0_EN
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | out_valid;
        end
        check("r0_skipped", 32'(seen), 32'd0);
`else
        seen = 1'b1;
        expect_word("r0_hdr", 16'h1000, 1'b0, 1'b0);
        expect_word("r0_data", 16'h5555, 1'b1, 1'b0);
        check("r0_seen", 32'(seen), 32'd1);
`endif
        check("r0_inst", inst_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
